// File: rtl/bist_pattern_engine_if.sv
// Controller-side handshake bundle for the BIST pattern engine: run request,
// captured run parameters and the status/signature returned to the controller.
interface bist_pattern_engine_if #(
  parameter int PI_W   = 13,
  parameter int CNT_W  = 16,
  parameter int MISR_W = 16
);
  logic              start;
  logic              abort;
  logic              mode;
  logic [PI_W-1:0]   seed;
  logic [CNT_W-1:0]  n_patterns;
  logic [MISR_W-1:0] exp_sig;
  logic              busy;
  logic              done;
  logic              pass;
  logic [MISR_W-1:0] signature;

  modport master (
    output start, abort, mode, seed, n_patterns, exp_sig,
    input  busy, done, pass, signature
  );

  modport slave (
    input  start, abort, mode, seed, n_patterns, exp_sig,
    output busy, done, pass, signature
  );
endinterface

// File: rtl/bist_pattern_engine.sv
// BIST engine: applies LFSR or counter patterns to a combinational CUT,
// compacts its responses in a MISR and compares against an expected signature.
module bist_pattern_engine #(
  parameter int                PI_W      = 13,
  parameter int                PO_W      = 1,
  parameter int                MISR_W    = 16,
  parameter int                CNT_W     = 16,
  parameter logic [PI_W-1:0]   LFSR_TAPS = 13'h100D,
  parameter logic [MISR_W-1:0] MISR_TAPS = 16'h8805
) (
  input  logic                  CLK,
  input  logic                  CLR_N,
  bist_pattern_engine_if.slave  ctrl,
  output logic [PI_W-1:0]       cut_pi,
  input  logic [PO_W-1:0]       cut_po
);

  if (PO_W > MISR_W) begin : g_po_w_check
    $error("bist_pattern_engine: PO_W must not exceed MISR_W");
  end

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t            state_reg, state_next;
  logic              mode_reg;
  logic [PI_W-1:0]   seed_reg;
  logic [CNT_W-1:0]  n_reg;
  logic [MISR_W-1:0] exp_reg;
  logic [PI_W-1:0]   pat_reg;
  logic [MISR_W-1:0] misr_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic              capture;
  logic [PI_W-1:0]   load_pat;
  logic [PI_W-1:0]   pat_next;
  logic [MISR_W-1:0] misr_next;

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    if (ctrl.abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: if (ctrl.start) begin
          state_next = LOAD;
          capture    = 1'b1;
        end
        LOAD: state_next = (n_reg == '0) ? DONE : RUN;
        RUN:  if (cnt_reg == CNT_W'(1)) state_next = DONE;
        DONE: if (ctrl.start) begin
          state_next = LOAD;
          capture    = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // An all-zero LFSR state never advances, so a zero seed is bumped to 1.
  always_comb begin
    load_pat = seed_reg;
    if (!mode_reg && seed_reg == '0) load_pat = PI_W'(1);
    pat_next  = mode_reg ? (pat_reg + PI_W'(1))
                         : {pat_reg[PI_W-2:0], ^(pat_reg & LFSR_TAPS)};
    misr_next = {misr_reg[MISR_W-2:0], ^(misr_reg & MISR_TAPS)} ^ MISR_W'(cut_po);
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      mode_reg <= 1'b0;
      seed_reg <= '0;
      n_reg    <= '0;
      exp_reg  <= '0;
      pat_reg  <= '0;
      misr_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      if (capture) begin
        mode_reg <= ctrl.mode;
        seed_reg <= ctrl.seed;
        n_reg    <= ctrl.n_patterns;
        exp_reg  <= ctrl.exp_sig;
      end
      // Abort freezes the datapath so the signature stays observable.
      if (!ctrl.abort) begin
        case (state_reg)
          LOAD: begin
            pat_reg  <= load_pat;
            misr_reg <= '0;
            cnt_reg  <= n_reg;
          end
          RUN: begin
            pat_reg  <= pat_next;
            misr_reg <= misr_next;
            cnt_reg  <= cnt_reg - CNT_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    ctrl.busy      = (state_reg == LOAD) || (state_reg == RUN);
    ctrl.done      = (state_reg == DONE);
    ctrl.pass      = (state_reg == DONE) && (misr_reg == exp_reg);
    ctrl.signature = misr_reg;
    cut_pi         = pat_reg;
  end

endmodule

// File: tb/tb_bist_pattern_engine.sv
// Self-checking bench for bist_pattern_engine: directed and randomized runs
// compared against a pattern/signature model built from the polynomial rules.
module tb_bist_pattern_engine;
  localparam int PI_W = 13, PO_W = 1, MISR_W = 16, CNT_W = 16;

  logic CLK = 1'b0;
  logic CLR_N = 1'b0;
  always #5 CLK = ~CLK;

  bist_pattern_engine_if #(.PI_W(PI_W), .CNT_W(CNT_W), .MISR_W(MISR_W)) ctrl ();
  logic [PI_W-1:0] cut_pi;
  logic [PO_W-1:0] cut_po;
  int              cut_sel = 0;

  always_comb cut_po = (cut_sel == 0) ? cut_pi[0] : ^(cut_pi & 13'h1A35);

  bist_pattern_engine dut (
    .CLK    (CLK),
    .CLR_N  (CLR_N),
    .ctrl   (ctrl),
    .cut_pi (cut_pi),
    .cut_po (cut_po)
  );

  int checks = 0;
  int errors = 0;
  logic [PI_W-1:0] obs_pats[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Polynomial x^13+x^4+x^3+x+1 as a shift-left Fibonacci register: taps 12,3,2,0.
  function automatic logic [12:0] model_next(input bit m, input logic [12:0] p);
    if (m) return p + 13'd1;
    return {p[11:0], p[12] ^ p[3] ^ p[2] ^ p[0]};
  endfunction

  function automatic bit model_cut(input int sel, input logic [12:0] p);
    if (sel == 0) return p[0];
    return ^(p & 13'h1A35);
  endfunction

  // x^16+x^12+x^3+x+1: feedback from bits 15,11,2,0.
  function automatic logic [15:0] model_misr(input logic [15:0] s, input bit po);
    return {s[14:0], s[15] ^ s[11] ^ s[2] ^ s[0]} ^ {15'd0, po};
  endfunction

  task automatic run_test(input string tag, input bit m, input logic [12:0] sd, input int n,
                          input logic [15:0] exp_in, input bit exp_from_model,
                          input int glitch_at, output logic [15:0] sig_out);
    logic [12:0] pats[$];
    logic [12:0] p;
    logic [15:0] sig;
    logic [15:0] exp;
    pats.delete();
    obs_pats.delete();
    p = (!m && sd == 13'd0) ? 13'd1 : sd;
    sig = 16'd0;
    for (int i = 0; i < n; i++) begin
      pats.push_back(p);
      sig = model_misr(sig, model_cut(cut_sel, p));
      p = model_next(m, p);
    end
    exp = exp_from_model ? sig : exp_in;
    sig_out = sig;

    @(posedge CLK); #1;
    ctrl.start = 1'b1; ctrl.mode = m; ctrl.seed = sd;
    ctrl.n_patterns = n[15:0]; ctrl.exp_sig = exp;
    @(posedge CLK); #1;
    ctrl.start = 1'b0;
    ctrl.mode = ~m; ctrl.seed = 13'($urandom); ctrl.n_patterns = 16'd7; ctrl.exp_sig = ~exp;
    check({tag, ".load_busy"}, ctrl.busy, 1'b1);
    check({tag, ".load_done"}, ctrl.done, 1'b0);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      obs_pats.push_back(cut_pi);
      check({tag, ".cut_pi"}, cut_pi, pats[i]);
      check({tag, ".run_busy"}, ctrl.busy, 1'b1);
      check({tag, ".run_done"}, ctrl.done, 1'b0);
      check({tag, ".run_pass"}, ctrl.pass, 1'b0);
      if (i == glitch_at) begin
        ctrl.start = 1'b1; ctrl.mode = $urandom_range(0, 1); ctrl.seed = 13'($urandom);
        ctrl.n_patterns = 16'd3;
      end
      if (i == glitch_at + 1) ctrl.start = 1'b0;
    end
    @(posedge CLK); #1;
    check({tag, ".done"}, ctrl.done, 1'b1);
    check({tag, ".busy_end"}, ctrl.busy, 1'b0);
    check({tag, ".signature"}, ctrl.signature, sig);
    check({tag, ".pass"}, ctrl.pass, (sig == exp));
    $display("run %s mode=%0d seed=%h n=%0d sig=%h exp=%h pass=%0b", tag, m, sd, n,
             ctrl.signature, exp, ctrl.pass);
  endtask

  initial begin
    logic [15:0] sig;
    bit seen[8192];
    int repeats;
    ctrl.start = 1'b0; ctrl.abort = 1'b0; ctrl.mode = 1'b0;
    ctrl.seed = '0; ctrl.n_patterns = '0; ctrl.exp_sig = '0;

    #1;
    check("rst.cut_pi", cut_pi, 13'd0);
    check("rst.signature", ctrl.signature, 16'd0);
    check("rst.busy", ctrl.busy, 1'b0);
    check("rst.done", ctrl.done, 1'b0);
    check("rst.pass", ctrl.pass, 1'b0);
    repeat (2) @(negedge CLK);
    CLR_N = 1'b1;

    // Exhaustive compaction with cut_po = cut_pi[0]
    cut_sel = 0;
    run_test("exh", 1'b1, 13'd0, 4, 16'h0006, 1'b0, -1, sig);
    check("exh.sig_const", sig, 16'h0006);
    run_test("exh_bad", 1'b1, 13'd0, 4, 16'h0007, 1'b0, -1, sig);

    run_test("zero_seed", 1'b0, 13'd0, 2, 16'h0000, 1'b1, -1, sig);
    run_test("wrap", 1'b1, 13'h1FFF, 2, 16'h0000, 1'b1, -1, sig);
    run_test("n0", 1'b0, 13'h0123, 0, 16'h0000, 1'b0, -1, sig);
    check("n0.sig_zero", sig, 16'h0000);

    // LFSR period: 8191 distinct states, then back to the seed
    cut_sel = 1;
    run_test("period", 1'b0, 13'h0001, 8191, 16'h0000, 1'b1, -1, sig);
    repeats = 0;
    foreach (obs_pats[i]) begin
      if (seen[obs_pats[i]]) repeats++;
      seen[obs_pats[i]] = 1'b1;
    end
    check("period.unique", repeats, 0);
    check("period.count", obs_pats.size(), 8191);
    run_test("period_wrap", 1'b0, 13'h0001, 8192, 16'h0000, 1'b1, -1, sig);
    check("period_wrap.last", obs_pats[8191], 13'h0001);

    // start during RUN is ignored
    run_test("glitch", 1'b0, 13'h0ABC, 12, 16'h0000, 1'b1, 3, sig);

    // abort + start in DONE
    @(posedge CLK); #1;
    ctrl.abort = 1'b1; ctrl.start = 1'b1;
    @(posedge CLK); #1;
    ctrl.abort = 1'b0; ctrl.start = 1'b0;
    check("abort.done", ctrl.done, 1'b0);
    check("abort.busy", ctrl.busy, 1'b0);
    check("abort.pass", ctrl.pass, 1'b0);
    check("abort.sig_held", ctrl.signature, sig);
    @(posedge CLK); #1;
    check("abort.idle", ctrl.busy, 1'b0);
    $display("abort+start in DONE: done=%0b busy=%0b sig=%h", ctrl.done, ctrl.busy, ctrl.signature);

    // Reset in the middle of a run
    @(posedge CLK); #1;
    ctrl.start = 1'b1; ctrl.mode = 1'b0; ctrl.seed = 13'h0005; ctrl.n_patterns = 16'd50;
    @(posedge CLK); #1;
    ctrl.start = 1'b0;
    repeat (10) @(posedge CLK);
    #2 CLR_N = 1'b0;
    #1;
    check("midrst.cut_pi", cut_pi, 13'd0);
    check("midrst.signature", ctrl.signature, 16'd0);
    check("midrst.busy", ctrl.busy, 1'b0);
    check("midrst.done", ctrl.done, 1'b0);
    check("midrst.pass", ctrl.pass, 1'b0);
    @(negedge CLK);
    CLR_N = 1'b1;
    @(posedge CLK); #1;
    check("midrst.idle", ctrl.busy, 1'b0);
    $display("reset mid-run: busy=%0b done=%0b sig=%h", ctrl.busy, ctrl.done, ctrl.signature);
    run_test("after_rst", 1'b1, 13'h0010, 5, 16'h0000, 1'b1, -1, sig);

    // Randomized runs against the model
    for (int r = 0; r < 8; r++) begin
      run_test($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 13'($urandom),
               int'($urandom_range(1, 40)), 16'($urandom), 1'($urandom_range(0, 1)), -1, sig);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
